// File: rtl/pair_detect_pkg.sv
// Shared encodings and helpers for the pair detector controller.
package pair_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ALARM  = 2'b10
  } state_t;

  localparam int unsigned MODE_ANY = 0;
  localparam int unsigned MODE_ALL = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_debounce.sv
// One input channel: 2-flop synchroniser followed by a mismatch-run debouncer.
module chan_debounce
  import pair_detect_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_nodeb
      assign dout = sync2;
    end else begin : g_deb
      localparam int unsigned CW = clog2(DEB_CYCLES + 1);
      logic [CW-1:0] cnt;
      logic          stable;

      // Stable flips only after DEB_CYCLES consecutive mismatching samples.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          stable <= 1'b0;
        end else if (sync2 != stable) begin
          if (cnt == CW'(DEB_CYCLES - 1)) begin
            stable <= sync2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign dout = stable;
    end
  endgenerate

endmodule

// File: rtl/pair_detect_ctrl.sv
// Debounced H/B pair detector with hold-time alarm and saturating event counter.
module pair_detect_ctrl
  import pair_detect_pkg::*;
#(
  parameter int unsigned N_H         = 2,
  parameter int unsigned N_B         = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned MODE        = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_H-1:0]   H,
  input  logic [N_B-1:0]   B,
  input  logic             Ack,
  input  logic             Clr_cnt,
  output logic             P,
  output logic             Alarm,
  output logic [CNT_W-1:0] Event_cnt,
  output logic [1:0]       State
);

  localparam int unsigned HW = clog2(HOLD_CYCLES + 1);

  logic [N_H-1:0] h_stable;
  logic [N_B-1:0] b_stable;
  logic           det;
  logic           p_d;
  state_t         state, next_state;
  logic [HW-1:0]  hold_cnt, hold_next;

  generate
    for (genvar i = 0; i < N_H; i++) begin : g_h
      chan_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (H[i]),
        .dout (h_stable[i])
      );
    end
    for (genvar i = 0; i < N_B; i++) begin : g_b
      chan_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (B[i]),
        .dout (b_stable[i])
      );
    end
  endgenerate

  always_comb begin
    if (MODE == MODE_ALL) det = (&h_stable) & (&b_stable);
    else                  det = (|h_stable) & (|b_stable);
  end

  // A single-cycle hold requirement alarms on the very edge IDLE sees P high.
  always_comb begin
    next_state = state;
    hold_next  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (P) begin
          hold_next  = HW'(1);
          next_state = (HOLD_CYCLES == 1) ? ST_ALARM : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (P) begin
          hold_next = hold_cnt + HW'(1);
          if (hold_next == HW'(HOLD_CYCLES)) next_state = ST_ALARM;
        end else begin
          hold_next  = '0;
          next_state = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (Ack && !P) begin
          hold_next  = '0;
          next_state = ST_IDLE;
        end
      end
      default: begin
        hold_next  = '0;
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      Alarm     <= 1'b0;
      P         <= 1'b0;
      p_d       <= 1'b0;
      Event_cnt <= '0;
    end else begin
      state    <= next_state;
      hold_cnt <= hold_next;
      Alarm    <= (next_state == ST_ALARM);
      P        <= det;
      p_d      <= P;
      if (Clr_cnt)                             Event_cnt <= '0;
      else if (P && !p_d && (Event_cnt != '1)) Event_cnt <= Event_cnt + CNT_W'(1);
    end
  end

  assign State = state;

endmodule

// File: tb/tb_pair_detect_ctrl.sv
// Randomised and directed checks of three pair_detect_ctrl configurations against a window-based model.
module tb_pair_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] h_in;
  logic [1:0] b_in;
  logic       ack, clr;

  logic       p0, p1, p2, al0, al1, al2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [1:0] st0, st1, st2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pair_detect_ctrl #(.N_H(2), .N_B(2), .DEB_CYCLES(4), .HOLD_CYCLES(8), .MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .H(h_in[1:0]), .B(b_in), .Ack(ack), .Clr_cnt(clr),
    .P(p0), .Alarm(al0), .Event_cnt(cnt0), .State(st0));

  pair_detect_ctrl #(.N_H(3), .N_B(2), .DEB_CYCLES(1), .HOLD_CYCLES(3), .MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .H(h_in), .B(b_in), .Ack(ack), .Clr_cnt(clr),
    .P(p1), .Alarm(al1), .Event_cnt(cnt1), .State(st1));

  pair_detect_ctrl #(.N_H(2), .N_B(2), .DEB_CYCLES(0), .HOLD_CYCLES(1), .MODE(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .H(h_in[1:0]), .B(b_in), .Ack(ack), .Clr_cnt(clr),
    .P(p2), .Alarm(al2), .Event_cnt(cnt2), .State(st2));

  // Per-configuration model parameters, indexed by DUT number.
  int unsigned c_nh[3]   = '{2, 3, 2};
  int unsigned c_deb[3]  = '{4, 1, 0};
  int unsigned c_hold[3] = '{8, 3, 1};
  int unsigned c_mode[3] = '{0, 1, 0};
  int unsigned c_cntw[3] = '{8, 8, 2};

  logic [4:0]  hist[$];   // input sampled at each edge since reset, {h[2:0], b[1:0]}
  logic [4:0]  st_m[3];
  bit          p_m[3], pd_m[3], al_m[3];
  int unsigned run_m[3], cnt_m[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] xs(input int k);
    if (k < 1 || k > hist.size()) return '0;
    return hist[k-1];
  endfunction

  function automatic bit det_m(input int d, input logic [4:0] s);
    bit any_h, all_h, any_b, all_b;
    any_h = 0; all_h = 1; any_b = 0; all_b = 1;
    for (int unsigned i = 0; i < c_nh[d]; i++) begin
      any_h = any_h | s[2+i];
      all_h = all_h & s[2+i];
    end
    for (int unsigned i = 0; i < 2; i++) begin
      any_b = any_b | s[i];
      all_b = all_b & s[i];
    end
    return (c_mode[d] == 1) ? (all_h && all_b) : (any_h && any_b);
  endfunction

  function automatic int unsigned st_exp(input int d);
    if (al_m[d]) return 2;
    return (run_m[d] > 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 3; d++) begin
      st_m[d] = '0; p_m[d] = 0; pd_m[d] = 0; al_m[d] = 0; run_m[d] = 0; cnt_m[d] = 0;
    end
  endtask

  // Advance the model across one rising edge using the pre-edge values.
  task automatic model_edge();
    int t;
    bit pre_p, newp, v, same;
    logic [4:0] w;
    hist.push_back({h_in, b_in});
    t = hist.size();
    for (int d = 0; d < 3; d++) begin
      pre_p = p_m[d];
      newp  = det_m(d, st_m[d]);
      if (clr) cnt_m[d] = 0;
      else if (pre_p && !pd_m[d] && cnt_m[d] < ((1 << c_cntw[d]) - 1)) cnt_m[d]++;
      pd_m[d] = pre_p;
      if (al_m[d]) begin
        if (ack && !pre_p) begin al_m[d] = 0; run_m[d] = 0; end
      end else if (pre_p) begin
        run_m[d]++;
        if (run_m[d] >= c_hold[d]) al_m[d] = 1;
      end else begin
        run_m[d] = 0;
      end
      if (c_deb[d] == 0) begin
        st_m[d] = xs(t - 1);
      end else begin
        for (int c = 0; c < 5; c++) begin
          w = xs(t - 2);
          v = w[c];
          same = 1;
          for (int k = t - 1 - int'(c_deb[d]); k <= t - 2; k++) begin
            w = xs(k);
            if (w[c] != v) same = 0;
          end
          if (same && v != st_m[d][c]) st_m[d][c] = v;
        end
      end
      p_m[d] = newp;
    end
  endtask

  task automatic compare_all();
    check("p0", p0, p_m[0]);   check("al0", al0, al_m[0]);
    check("cnt0", cnt0, cnt_m[0]); check("st0", st0, st_exp(0));
    check("p1", p1, p_m[1]);   check("al1", al1, al_m[1]);
    check("cnt1", cnt1, cnt_m[1]); check("st1", st1, st_exp(1));
    check("p2", p2, p_m[2]);   check("al2", al2, al_m[2]);
    check("cnt2", cnt2, cnt_m[2]); check("st2", st2, st_exp(2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_p0", p0, 0);   check("rst_al0", al0, 0);
    check("rst_cnt0", cnt0, 0); check("rst_st0", st0, 0);
    check("rst_p1", p1, 0);   check("rst_al1", al1, 0);
    check("rst_cnt2", cnt2, 0); check("rst_st2", st2, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    bit old_p, new_p, pre;
    int unsigned k, c0, rises, guard;
    logic [3:0] combo;

    h_in = '0; b_in = '0; ack = 0; clr = 0; rst_n = 1'b0;
    #2;
    do_reset();

    // Truth sweep with explicit latency checks on the DEB_CYCLES=4 instance.
    old_p = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      combo = 4'(i);
      h_in  = {1'($urandom_range(1)), combo[3:2]};
      b_in  = combo[1:0];
      new_p = (combo[3:2] != 2'b00) && (combo[1:0] != 2'b00);
      for (int j = 1; j <= 20; j++) begin
        step();
        if (j == 6) check("lat_pre", p0, old_p);
        if (j == 7) check("lat_post", p0, new_p);
      end
      old_p = new_p;
    end

    // Clear any alarms, then glitch rejection.
    h_in = '0; b_in = '0;
    repeat (12) step();
    ack = 1; step(); ack = 0;
    h_in = 3'b001; b_in = 2'b01;
    repeat (12) step();
    c0 = cnt0;
    b_in = 2'b00;
    repeat (3) step();
    b_in = 2'b01;
    repeat (12) begin
      step();
      check("glitch_p", p0, 1);
      check("glitch_cnt", cnt0, c0);
    end

    // Alarm after 8 P-high edges, ignored Ack, then Ack with P low.
    h_in = '0; b_in = '0;
    repeat (12) step();
    ack = 1; step(); ack = 0;
    check("alarm_clear", al0, 0);
    h_in = 3'b011; b_in = 2'b11;
    k = 0;
    repeat (20) begin
      pre = p0;
      step();
      if (pre) k++;
      check("alarm_hold", al0, (k >= 8) ? 1 : 0);
    end
    ack = 1; step(); ack = 0;
    check("ack_ignored", al0, 1);
    check("ack_ignored_st", st0, 2);
    h_in = '0; b_in = '0;
    repeat (10) step();
    ack = 1; step(); ack = 0;
    check("ack_al", al0, 0);
    check("ack_st", st0, 0);

    // All-mode instance.
    h_in = 3'b110; b_in = 2'b11;
    repeat (10) step();
    check("mode1_partial", p1, 0);
    h_in = 3'b111;
    repeat (10) step();
    check("mode1_full", p1, 1);

    // Saturation of the 2-bit counter, then Clr_cnt colliding with a rise.
    h_in = 3'b011; b_in = 2'b00;
    repeat (6) step();
    clr = 1; step(); clr = 0;
    rises = 0;
    repeat (5) begin
      b_in = 2'b11; repeat (4) step();
      b_in = 2'b00; repeat (4) step();
      rises++;
    end
    check("sat_cnt2", cnt2, 3);
    b_in = 2'b11;
    guard = 0;
    while (!(p_m[2] && !pd_m[2]) && guard < 20) begin
      step();
      guard++;
    end
    check("rise_found", (guard < 20) ? 1 : 0, 1);
    clr = 1; step(); clr = 0;
    check("clr_vs_rise", cnt2, 0);

    // Randomised traffic with slowly changing inputs.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) begin
        k = $urandom_range(4);
        if (k < 3) h_in[k] = ~h_in[k];
        else       b_in[k-3] = ~b_in[k-3];
      end
      ack = ($urandom_range(7) == 0);
      clr = ($urandom_range(39) == 0);
      step();
    end
    ack = 0; clr = 0;

    // Asynchronous reset while in ALARM.
    h_in = 3'b111; b_in = 2'b11;
    guard = 0;
    while (!al_m[0] && guard < 60) begin
      step();
      guard++;
    end
    check("pre_rst_alarm", al0, 1);
    do_reset();
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pair_detect_ctrl.md
Name: pair_detect_ctrl

Overview:
- Parametrised, clocked successor of the two-H/two-B pair detector.
- Takes N_H "H" inputs and N_B "B" inputs from asynchronous switches or sensors. Each input is synchronised and debounced.
- The stable inputs are combined into a registered detect output P.
- A sticky alarm is raised when P is held for HOLD_CYCLES; a firmware-visible event counter tracks P rising edges.

Parameters:
- N_H, 2, number of H channels (1..16)
- N_B, 2, number of B channels (1..16)
- DEB_CYCLES, 4, consecutive stable cycles required to accept an input change; 0 = no debounce
- HOLD_CYCLES, 8, consecutive cycles P must stay high before ALARM (>=1)
- MODE, 0, 0 = P when (any H) AND (any B); 1 = P when (all H) AND (all B)
- CNT_W, 8, event counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- H  in  N_H  asynchronous H channel inputs
- B  in  N_B  asynchronous B channel inputs
- Ack  in  1  alarm acknowledge, synchronous, single-cycle pulse
- Clr_cnt  in  1  synchronous clear of Event_cnt
- P  out  1  registered detect output
- Alarm  out  1  sticky alarm
- Event_cnt  out  CNT_W  saturating count of P rising edges
- State  out  2  current FSM state, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, debounce counters, stable values, P, Alarm, Event_cnt and hold counter are cleared to 0. State = IDLE (2'b00). Release is synchronous to clk.
- Synchroniser: 2 flops per channel.
- Debounce, per channel:
  - Each channel holds a stable value and a counter of width clog2(DEB_CYCLES+1).
  - If sync != stable, the counter increments. When the counter reaches DEB_CYCLES-1 while the mismatch persists, stable takes sync on the next edge and the counter clears.
  - Any cycle with sync == stable clears the counter (glitch rejected).
  - DEB_CYCLES=0: stable = sync directly.
- Combine:
  - MODE0: det = |H_stable & |B_stable.
  - MODE1: det = &H_stable & &B_stable.
  - P <= det, registered.
- Latency: a clean input step that satisfies the combine condition reaches P exactly 3+DEB_CYCLES clock edges after the first edge that samples it. The same holds for deassertion.
- FSM states: IDLE (P=0), ACTIVE (P=1, hold counter running), ALARM (alarm condition latched).
  - IDLE -> ACTIVE when P=1. The hold counter loads 1.
  - ACTIVE: if P=1, the counter increments; on reaching HOLD_CYCLES, go to ALARM and set Alarm=1 on the same edge. If P=0, go to IDLE and clear the counter.
  - ALARM: Alarm stays 1 regardless of P. Ack with P=0 -> IDLE, Alarm=0 next edge. Ack with P=1 is ignored (stays ALARM).
  - State encoding: IDLE=00, ACTIVE=01, ALARM=10. 11 is unreachable; if ever entered, next state is IDLE.
- Event_cnt:
  - Increments by 1 on each P 0->1 transition, detected with a registered copy of P.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Clr_cnt has priority over a simultaneous increment; the result is 0.
- Reset mid-operation: asynchronous return to the reset values above, including in the ALARM state. A pending debounce count is discarded.
- Outputs change only on clk rising edges, except on asynchronous reset.

Decomposition:
- Package pair_detect_pkg holds:
  - state encodings ST_IDLE/ST_ACTIVE/ST_ALARM;
  - MODE_ANY=0 and MODE_ALL=1;
  - a clog2 constant function.
- Sub-module chan_debounce (params DEB_CYCLES; ports clk, rst_n, din, dout) contains the 2-flop synchroniser plus the debounce counter. It is instantiated N_H+N_B times via generate.
- The top level holds the combine logic, FSM, hold counter and event counter.

Test Plan:
- Reset: drive H=2'b11, B=2'b11, assert rst_n=0 mid-ALARM -> P=0, Alarm=0, Event_cnt=0 and State=00 immediately, without waiting for a clk edge.
- Truth sweep, MODE0, DEB_CYCLES=4: walk all 16 H/B combinations, 20 cycles each -> P=1 exactly for combos with H!=0 and B!=0, appearing 7 edges after each input change.
- Glitch rejection, DEB_CYCLES=4: H=01, B=01 stable, pulse B to 00 for 3 cycles -> P stays 1, Event_cnt unchanged.
- Alarm and Ack, HOLD_CYCLES=8:
  - Hold P=1 for 10 cycles -> Alarm rises on the 8th P-high edge.
  - Ack while P=1 -> ignored.
  - Drop inputs, then Ack -> Alarm=0 next edge, State=IDLE.
- MODE1 with N_H=3, N_B=2: H=3'b110, B=2'b11 -> P=0; then H=3'b111 -> P=1.
- Counter, CNT_W=2: produce 5 P rising edges -> Event_cnt=3 (saturated). Clr_cnt on the same cycle as a 6th rising edge -> Event_cnt=0.
